// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU command codes, branch types,
// forwarding-select codes and the multiplier FSM states, plus the operand
// forwarding mux used for both ALU inputs.
package exe_pkg;

    typedef enum logic [3:0] {
        ExeAdd = 4'b0000,
        ExeSub = 4'b0010,
        ExeAnd = 4'b0100,
        ExeOr  = 4'b0101,
        ExeNor = 4'b0110,
        ExeXor = 4'b0111,
        ExeSla = 4'b1000,
        ExeSll = 4'b1001,
        ExeSra = 4'b1010,
        ExeSrl = 4'b1100,
        ExeMul = 4'b1111
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BrNone = 2'b00,
        BrBez  = 2'b01,
        BrBne  = 2'b10,
        BrJmp  = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        FwdReg  = 2'b00,
        FwdMem  = 2'b01,
        FwdWb   = 2'b10,
        FwdReg2 = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MulIdle = 2'b00,
        MulBusy = 2'b01,
        MulDone = 2'b10
    } mul_state_e;

    // Code 11 is unused by the hazard unit and falls back to the register value.
    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] reg_val,
                                            input logic [31:0] mem_val,
                                            input logic [31:0] wb_val);
        logic [31:0] res;
        res = reg_val;
        if (sel == FwdMem) begin
            res = mem_val;
        end else if (sel == FwdWb) begin
            res = wb_val;
        end
        return res;
    endfunction

endpackage

// File: rtl/iter_mult.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   start     multiply request; operands sampled only while idle
//   a, b      multiplicand and multiplier
//   busy      stage must stall (request being accepted or iterating)
//   done      product valid for this single cycle
//   product   low MUL_ITER bits of a*b
module iter_mult
    import exe_pkg::*;
#(
    parameter int unsigned MUL_ITER = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MUL_ITER-1:0] a,
    input  logic [MUL_ITER-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [MUL_ITER-1:0] product
);

    localparam int unsigned CntW = $clog2(MUL_ITER);
    localparam logic [CntW-1:0] CntLast = CntW'(MUL_ITER - 1);

    mul_state_e          state_q;
    logic [CntW-1:0]     cnt_q;
    logic [MUL_ITER-1:0] acc_q;
    logic [MUL_ITER-1:0] mcand_q;
    logic [MUL_ITER-1:0] mplier_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MulIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            unique case (state_q)
                MulIdle: begin
                    if (start) begin
                        mcand_q  <= a;
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= MulBusy;
                    end
                end
                MulBusy: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q <= MulDone;
                    end
                end
                MulDone: begin
                    // ID/EX loads the next instruction on this edge.
                    state_q <= MulIdle;
                end
                default: begin
                    state_q <= MulIdle;
                end
            endcase
        end
    end

    // The accepting cycle stalls too, so the front end holds the MUL in ID/EX.
    assign busy    = (state_q == MulBusy) || ((state_q == MulIdle) && start);
    assign done    = (state_q == MulDone);
    assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand forwarding, single-cycle
// ALU, branch resolution and control gating, with an iterative multiplier
// that stalls the front end and bubbles EX/MEM while it runs.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   exe_cmd, br_type, is_imm         decoded control from ID/EX
//   immediate, pc, readdata1/2       data from ID/EX (pc is PC+4)
//   wb_en_in, mem_r_en_in,
//   mem_w_en_in, dest_in             write-back/memory control from ID/EX
//   fwd_sel1/2, mem_fwd_val,
//   wb_fwd_val                       forwarding selects and forwarded values
//   alu_result, st_val               result and store data to EX/MEM
//   wb_en, mem_r_en, mem_w_en, dest  gated control to EX/MEM
//   br_taken, br_addr                branch redirect
//   exe_stall                        hold PC, IF/ID and ID/EX
module exe_stage
    import exe_pkg::*;
#(
    parameter int unsigned MUL_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  exe_cmd,
    input  logic [1:0]  br_type,
    input  logic        is_imm,
    input  logic [31:0] immediate,
    input  logic [31:0] pc,
    input  logic [31:0] readdata1,
    input  logic [31:0] readdata2,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [4:0]  dest_in,
    input  logic [1:0]  fwd_sel1,
    input  logic [1:0]  fwd_sel2,
    input  logic [31:0] mem_fwd_val,
    input  logic [31:0] wb_fwd_val,
    output logic [31:0] alu_result,
    output logic [31:0] st_val,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [4:0]  dest,
    output logic        br_taken,
    output logic [31:0] br_addr,
    output logic        exe_stall
);

    logic [31:0] op_a;
    logic [31:0] op_b_reg;
    logic [31:0] op_b;
    logic [31:0] alu_out;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        br_cond;

    assign op_a     = fwd_mux(fwd_sel1, readdata1, mem_fwd_val, wb_fwd_val);
    assign op_b_reg = fwd_mux(fwd_sel2, readdata2, mem_fwd_val, wb_fwd_val);
    assign op_b     = is_imm ? immediate : op_b_reg;
    assign st_val   = op_b_reg;

    always_comb begin
        alu_out = '0;
        case (exe_cmd)
            ExeAdd:         alu_out = op_a + op_b;
            ExeSub:         alu_out = op_a - op_b;
            ExeAnd:         alu_out = op_a & op_b;
            ExeOr:          alu_out = op_a | op_b;
            ExeNor:         alu_out = ~(op_a | op_b);
            ExeXor:         alu_out = op_a ^ op_b;
            ExeSla, ExeSll: alu_out = op_a << op_b[4:0];
            ExeSra:         alu_out = $unsigned($signed(op_a) >>> op_b[4:0]);
            ExeSrl:         alu_out = op_a >> op_b[4:0];
            ExeMul:         alu_out = mul_done ? mul_product : '0;
            default:        alu_out = '0;
        endcase
    end

    iter_mult #(
        .MUL_ITER(MUL_ITER)
    ) u_iter_mult (
        .clk    (clk),
        .rst    (rst),
        .start  (exe_cmd == ExeMul),
        .a      (op_a),
        .b      (op_b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

    assign exe_stall = mul_busy;

    always_comb begin
        br_cond = 1'b0;
        unique case (br_type)
            BrNone: br_cond = 1'b0;
            BrBez:  br_cond = (op_a == '0);
            BrBne:  br_cond = (op_a != op_b);
            BrJmp:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken = br_cond & ~exe_stall;
    assign br_addr  = pc + (immediate << 2);

    assign alu_result = alu_out;
    assign dest       = dest_in;
    assign wb_en      = wb_en_in    & ~exe_stall;
    assign mem_r_en   = mem_r_en_in & ~exe_stall;
    assign mem_w_en   = mem_w_en_in & ~exe_stall;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic [3:0]  exe_cmd;
    logic [1:0]  br_type;
    logic        is_imm;
    logic [31:0] immediate;
    logic [31:0] pc;
    logic [31:0] readdata1;
    logic [31:0] readdata2;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [4:0]  dest_in;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
    logic [31:0] mem_fwd_val;
    logic [31:0] wb_fwd_val;
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [4:0]  dest;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        exe_stall;

    exe_stage dut (
        .clk        (clk),
        .rst        (rst),
        .exe_cmd    (exe_cmd),
        .br_type    (br_type),
        .is_imm     (is_imm),
        .immediate  (immediate),
        .pc         (pc),
        .readdata1  (readdata1),
        .readdata2  (readdata2),
        .wb_en_in   (wb_en_in),
        .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in),
        .dest_in    (dest_in),
        .fwd_sel1   (fwd_sel1),
        .fwd_sel2   (fwd_sel2),
        .mem_fwd_val(mem_fwd_val),
        .wb_fwd_val (wb_fwd_val),
        .alu_result (alu_result),
        .st_val     (st_val),
        .wb_en      (wb_en),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .dest       (dest),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .exe_stall  (exe_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        string       name;
        logic [3:0]  cmd;
        logic [1:0]  br;
        logic        imm_sel;
        logic [31:0] imm;
        logic [31:0] pcv;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [31:0] memf;
        logic [31:0] wbf;
        logic [2:0]  ctl;
        logic [31:0] exp_res;
        logic [31:0] exp_st;
        logic        exp_br;
        logic [31:0] exp_ba;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic clear_inputs();
        exe_cmd = 4'h0; br_type = 2'b00; is_imm = 1'b0; immediate = '0; pc = '0;
        readdata1 = '0; readdata2 = '0; wb_en_in = 1'b0; mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0; dest_in = '0; fwd_sel1 = 2'b00; fwd_sel2 = 2'b00;
        mem_fwd_val = '0; wb_fwd_val = '0;
    endtask

    function automatic vec_t mk(input string n, input logic [3:0] cmd, input logic [1:0] br,
                                input logic is_i, input logic [31:0] imm, input logic [31:0] pcv,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [1:0] s1, input logic [1:0] s2,
                                input logic [31:0] memf, input logic [31:0] wbf,
                                input logic [2:0] ctl, input logic [31:0] res,
                                input logic [31:0] st, input logic brt, input logic [31:0] ba);
        vec_t v;
        v.name = n; v.cmd = cmd; v.br = br; v.imm_sel = is_i; v.imm = imm; v.pcv = pcv;
        v.rd1 = rd1; v.rd2 = rd2; v.s1 = s1; v.s2 = s2; v.memf = memf; v.wbf = wbf;
        v.ctl = ctl; v.exp_res = res; v.exp_st = st; v.exp_br = brt; v.exp_ba = ba;
        return v;
    endfunction

    // Issue a MUL, change the forwarded operands after the capture cycle, and
    // check the bubble count, gating and the popped expected product.
    task automatic run_mul(input string n, input logic [31:0] a, input logic [31:0] b);
        int          stalls;
        logic        bad_gate;
        logic [31:0] exp;
        @(negedge clk);
        clear_inputs();
        exe_cmd = 4'hF; readdata1 = a; readdata2 = b;
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1; dest_in = 5'd9;
        sb_q.push_back(a * b);
        stalls = 0;
        bad_gate = 1'b0;
        #1;
        while (exe_stall && stalls < 40) begin
            stalls++;
            if (wb_en || mem_r_en || mem_w_en || br_taken) bad_gate = 1'b1;
            @(negedge clk);
            readdata1 = a ^ 32'h5A5A_1234;
            readdata2 = b + 32'd17;
            mem_fwd_val = 32'hDEAD_BEEF;
            #1;
        end
        chk({n, "_stalls"}, 32'(stalls), 32'd33);
        chk({n, "_gate"}, 32'(bad_gate), 32'd0);
        exp = sb_q.pop_front();
        chk({n, "_result"}, alu_result, exp);
        chk({n, "_wb_en"}, 32'(wb_en), 32'd1);
        chk({n, "_mem_w_en"}, 32'(mem_w_en), 32'd1);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_result", alu_result, 32'h0);
        chk("rst_br_taken", 32'(br_taken), 32'h0);
        chk("rst_br_addr", br_addr, 32'h0);
        chk("rst_stall", 32'(exe_stall), 32'h0);
        chk("rst_ctl", {29'b0, wb_en, mem_r_en, mem_w_en}, 32'h0);
        chk("rst_st_val", st_val, 32'h0);

        //          name        cmd    br     imm   immediate      pc             rd1            rd2
        //          s1     s2     memf           wbf            ctl     result         st_val    br   br_addr
        vecs.push_back(mk("add_fwd", 4'b0000, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'd7,
            2'b01, 2'b00, 32'd5, 32'h0, 3'b100, 32'd12, 32'd7, 1'b0, 32'h0));
        vecs.push_back(mk("sub", 4'b0010, 2'b00, 1'b0, 32'h1, 32'h10, 32'd3, 32'd5,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b010, 32'hFFFF_FFFE, 32'd5, 1'b0, 32'h14));
        vecs.push_back(mk("and", 4'b0100, 2'b00, 1'b0, 32'h0, 32'h0, 32'hF0F0_00FF, 32'h0FF0_0F0F,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b001, 32'h00F0_000F, 32'h0FF0_0F0F, 1'b0, 32'h0));
        vecs.push_back(mk("or", 4'b0101, 2'b00, 1'b0, 32'h0, 32'h0, 32'hF0F0_00FF, 32'h0FF0_0F0F,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b111, 32'hFFF0_0FFF, 32'h0FF0_0F0F, 1'b0, 32'h0));
        vecs.push_back(mk("nor", 4'b0110, 2'b00, 1'b0, 32'h0, 32'h0, 32'hF0F0_00FF, 32'h0FF0_0F0F,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b000, 32'h000F_F000, 32'h0FF0_0F0F, 1'b0, 32'h0));
        vecs.push_back(mk("xor", 4'b0111, 2'b00, 1'b0, 32'h0, 32'h0, 32'hF0F0_00FF, 32'h0FF0_0F0F,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b100, 32'hFF00_0FF0, 32'h0FF0_0F0F, 1'b0, 32'h0));
        vecs.push_back(mk("sll_imm", 4'b1001, 2'b00, 1'b1, 32'h24, 32'h0, 32'd1, 32'hDEAD,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b100, 32'h10, 32'hDEAD, 1'b0, 32'h90));
        vecs.push_back(mk("sla", 4'b1000, 2'b00, 1'b0, 32'h0, 32'h0, 32'd3, 32'd31,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b100, 32'h8000_0000, 32'd31, 1'b0, 32'h0));
        vecs.push_back(mk("sra", 4'b1010, 2'b00, 1'b0, 32'h0, 32'h0, 32'h8000_0000, 32'd4,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b100, 32'hF800_0000, 32'd4, 1'b0, 32'h0));
        vecs.push_back(mk("srl", 4'b1100, 2'b00, 1'b0, 32'h0, 32'h0, 32'h8000_0000, 32'd4,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b100, 32'h0800_0000, 32'd4, 1'b0, 32'h0));
        vecs.push_back(mk("undef", 4'b0011, 2'b00, 1'b0, 32'h0, 32'h0, 32'd5, 32'd6,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b100, 32'h0, 32'd6, 1'b0, 32'h0));
        vecs.push_back(mk("fwd_wb_mem", 4'b0000, 2'b00, 1'b0, 32'h0, 32'h0, 32'h999, 32'h777,
            2'b10, 2'b01, 32'h20, 32'h100, 3'b001, 32'h120, 32'h20, 1'b0, 32'h0));
        vecs.push_back(mk("fwd_sel11", 4'b0000, 2'b00, 1'b0, 32'h0, 32'h0, 32'd9, 32'd1,
            2'b11, 2'b11, 32'h55, 32'h66, 3'b100, 32'd10, 32'd1, 1'b0, 32'h0));
        vecs.push_back(mk("bne_taken", 4'b0000, 2'b10, 1'b0, 32'd2, 32'h100, 32'd3, 32'd4,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b000, 32'd7, 32'd4, 1'b1, 32'h108));
        vecs.push_back(mk("bne_equal", 4'b0000, 2'b10, 1'b0, 32'd2, 32'h100, 32'd4, 32'd4,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b000, 32'd8, 32'd4, 1'b0, 32'h108));
        vecs.push_back(mk("bez_taken", 4'b0000, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h200, 32'd0, 32'd5,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b000, 32'd5, 32'd5, 1'b1, 32'h1FC));
        vecs.push_back(mk("bez_nz", 4'b0000, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h200, 32'd1, 32'd5,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b000, 32'd6, 32'd5, 1'b0, 32'h1FC));
        vecs.push_back(mk("jmp", 4'b0000, 2'b11, 1'b0, 32'h10, 32'h40, 32'd7, 32'd0,
            2'b00, 2'b00, 32'h0, 32'h0, 3'b000, 32'd7, 32'd0, 1'b1, 32'h80));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clear_inputs();
            exe_cmd = vecs[i].cmd; br_type = vecs[i].br; is_imm = vecs[i].imm_sel;
            immediate = vecs[i].imm; pc = vecs[i].pcv;
            readdata1 = vecs[i].rd1; readdata2 = vecs[i].rd2;
            fwd_sel1 = vecs[i].s1; fwd_sel2 = vecs[i].s2;
            mem_fwd_val = vecs[i].memf; wb_fwd_val = vecs[i].wbf;
            {wb_en_in, mem_r_en_in, mem_w_en_in} = vecs[i].ctl;
            dest_in = 5'(i + 3);
            #1;
            chk({vecs[i].name, "_result"}, alu_result, vecs[i].exp_res);
            chk({vecs[i].name, "_st_val"}, st_val, vecs[i].exp_st);
            chk({vecs[i].name, "_br_taken"}, 32'(br_taken), 32'(vecs[i].exp_br));
            chk({vecs[i].name, "_br_addr"}, br_addr, vecs[i].exp_ba);
            chk({vecs[i].name, "_stall"}, 32'(exe_stall), 32'h0);
            chk({vecs[i].name, "_ctl"}, {29'b0, wb_en, mem_r_en, mem_w_en}, {29'b0, vecs[i].ctl});
            chk({vecs[i].name, "_dest"}, {27'b0, dest}, 32'(i + 3));
        end

        // MUL with a wrapping product, then a back-to-back MUL.
        run_mul("mul_wrap", 32'hFFFF_FFFF, 32'd3);
        run_mul("mul_b2b", 32'd7, 32'd6);

        // Next instruction after DONE is not stalled.
        @(negedge clk);
        clear_inputs();
        readdata1 = 32'd1; readdata2 = 32'd2; wb_en_in = 1'b1;
        #1;
        chk("post_mul_stall", 32'(exe_stall), 32'h0);
        chk("post_mul_result", alu_result, 32'd3);

        // Branch request while stalled must not redirect.
        @(negedge clk);
        clear_inputs();
        exe_cmd = 4'hF; br_type = 2'b11; readdata1 = 32'd5; readdata2 = 32'd7;
        #1;
        chk("stall_br_block", 32'(br_taken), 32'h0);
        chk("mul_issue_stall", 32'(exe_stall), 32'h1);

        // Reset in the middle of the iteration.
        repeat (10) @(negedge clk);
        #1;
        chk("busy_stall", 32'(exe_stall), 32'h1);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wb_en_in = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(exe_stall), 32'h0);
        chk("rst_mid_wb_en", 32'(wb_en), 32'h1);
        chk("rst_mid_result", alu_result, 32'h0);
        run_mul("mul_after_rst", 32'd2, 32'd2);

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
